// File: rtl/unpack_read_sched.sv
// unpack_read_sched: round-robin burst scheduler sharing one packed source among unpacker clients
module unpack_read_sched #(
  parameter int NUM_CLIENTS = 4,
  parameter int IN_WIDTH = 128,
  parameter int BURST_LEN = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   src_read_req,
  input  logic [IN_WIDTH-1:0]    src_read_data,
  input  logic                   src_read_ready,
  input  logic [NUM_CLIENTS-1:0] cli_req,
  input  logic [NUM_CLIENTS-1:0] cli_ready,
  output logic [NUM_CLIENTS-1:0] cli_grant,
  output logic [NUM_CLIENTS-1:0] cli_data_valid,
  output logic [IN_WIDTH-1:0]    cli_data,
  output logic [NUM_CLIENTS-1:0] cli_done
);
  localparam int PW = NUM_CLIENTS > 1 ? $clog2(NUM_CLIENTS) : 1;
  localparam int CW = $clog2(BURST_LEN + 1);
  typedef enum logic [1:0] {IDLE, BURST, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [PW-1:0] rr_ptr, owner, j, pick;
  logic [PW:0] sum;
  logic [NUM_CLIENTS-1:0] rot;
  logic [CW-1:0] issued;
  logic [IN_WIDTH-1:0] data_q;
  // rotate requests so bit 0 is rr_ptr, find the lowest set bit, then rotate the index back
  always_comb begin
    rot = NUM_CLIENTS'({cli_req, cli_req} >> rr_ptr);
    j = '0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--)
      if (rot[i]) j = PW'(i);
    sum = {1'b0, rr_ptr} + {1'b0, j};
    pick = sum >= (PW+1)'(NUM_CLIENTS) ? PW'(sum - (PW+1)'(NUM_CLIENTS)) : sum[PW-1:0];
  end
  always_comb begin
    src_read_req = !reset && state == BURST && src_read_ready && cli_ready[owner] && issued < CW'(BURST_LEN);
    state_nx = state == IDLE  ? (|cli_req ? BURST : IDLE) :
               state == BURST ? (src_read_req && issued == CW'(BURST_LEN - 1) ? DRAIN : BURST) :
               state == DRAIN ? DONE : IDLE;
    cli_done = state == DONE ? cli_grant : '0;
    cli_data = |cli_data_valid ? src_read_data : data_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      issued <= '0;
      cli_grant <= '0;
      cli_data_valid <= '0;
      data_q <= '0;
    end else begin
      state <= state_nx;
      cli_data_valid <= src_read_req ? cli_grant : '0;
      if (|cli_data_valid) data_q <= src_read_data;
      if (src_read_req) issued <= issued + 1'b1;
      if (state == IDLE && |cli_req) begin
        owner <= pick;
        cli_grant <= NUM_CLIENTS'(1) << pick;
        issued <= '0;
      end
      if (state == DONE) begin
        cli_grant <= '0;
        rr_ptr <= owner == PW'(NUM_CLIENTS - 1) ? '0 : owner + 1'b1;
      end
    end
  end
endmodule
